// File: rtl/enc16_pkg.sv
// rtl/enc16_pkg.sv - shared sizes and FSM state encoding for the 16-to-4 arbiter
package enc16_pkg;

    localparam int N_IN   = 16;
    localparam int CODE_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

endpackage

// File: rtl/pri_enc_16x4.sv
// rtl/pri_enc_16x4.sv - combinational 16-to-4 priority encoder, lowest set index wins
module pri_enc_16x4
    import enc16_pkg::*;
(
    input  logic [N_IN-1:0]   vec_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              found_o
);

    // Scan downward so the last hit written is the lowest set index.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = CODE_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enc_16x4_arb.sv
// rtl/enc_16x4_arb.sv - sticky 16-request arbiter offering a 4-bit code with valid/ack handshake
module enc_16x4_arb
    import enc16_pkg::*;
#(
    parameter int RR_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              En,
    input  logic [N_IN-1:0]   REQ,
    input  logic              ACK,
    output logic [CODE_W-1:0] CODE,
    output logic              VALID,
    output logic [N_IN-1:0]   PENDING
);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   ptr_q, ptr_d;
    logic [N_IN-1:0]     pending_q, pending_d;

    logic [CODE_W-1:0]   sel_code;
    logic                sel_found;
    logic                accept;
    logic [N_IN-1:0]     clr_mask;

    generate
        if (RR_MODE != 0) begin : g_rr
            logic [N_IN-1:0]   masked_vec;
            logic [CODE_W-1:0] idx_m, idx_u;
            logic              found_m, found_u;

            assign masked_vec = pending_q & ({N_IN{1'b1}} << ptr_q);

            pri_enc_16x4 u_pri_masked (
                .vec_i   (masked_vec),
                .idx_o   (idx_m),
                .found_o (found_m)
            );

            pri_enc_16x4 u_pri_all (
                .vec_i   (pending_q),
                .idx_o   (idx_u),
                .found_o (found_u)
            );

            // Fall back to the unmasked search when nothing sits at or above ptr.
            assign sel_code  = found_m ? idx_m : idx_u;
            assign sel_found = found_u;
        end else begin : g_fixed
            logic [N_IN-1:0]   rev_vec;
            logic [CODE_W-1:0] idx_r;
            logic              found_r;

            always_comb begin
                rev_vec = '0;
                for (int i = 0; i < N_IN; i++) begin
                    rev_vec[i] = pending_q[N_IN-1-i];
                end
            end

            pri_enc_16x4 u_pri_rev (
                .vec_i   (rev_vec),
                .idx_o   (idx_r),
                .found_o (found_r)
            );

            assign sel_code  = CODE_W'(N_IN - 1) - idx_r;
            assign sel_found = found_r;
        end
    endgenerate

    assign accept   = (state_q == OFFER) && ACK;
    assign clr_mask = accept ? (N_IN'(1) << code_q) : '0;

    // Clear before set so a same-cycle re-request of the granted bit survives.
    assign pending_d = (pending_q & ~clr_mask) | (REQ & {N_IN{En}});

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (En && sel_found) begin
                    state_d = OFFER;
                    code_d  = sel_code;
                end
            end
            OFFER: begin
                if (ACK) begin
                    state_d = IDLE;
                    if (RR_MODE != 0) begin
                        ptr_d = code_q + CODE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            code_q    <= '0;
            ptr_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
        end
    end

    assign CODE    = code_q;
    assign VALID   = (state_q == OFFER);
    assign PENDING = pending_q;

endmodule

// File: doc/enc_16x4_arb.md
ENC_16X4_ARB -- requirements
Module: enc_16x4_arb

Interface
REQ-001 The block SHALL have parameter RR_MODE, default 0, meaning 0 = fixed priority (highest index wins) and 1 = round-robin priority.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port En, input, 1, the request-capture enable.
REQ-005 The block SHALL have port REQ, input, 16, request lines, with bit i requesting code i.
REQ-006 The block SHALL have port ACK, input, 1, consumer acceptance of the current offer.
REQ-007 The block SHALL have port CODE, output, 4, the granted index, MSB-first, so CODE = {A,B,C,D} of the matching 4x16 decoder input.
REQ-008 The block SHALL have port VALID, output, 1, asserted while CODE is offered.
REQ-009 The block SHALL have port PENDING, output, 16, the registered sticky request vector.

Function
REQ-010 On each clock, PENDING SHALL update to (PENDING | (REQ & {16{En}})) with the bit CODE cleared when VALID & ACK.
REQ-011 When the same bit is set by REQ and cleared by the handshake in one cycle, set SHALL win and the bit SHALL remain 1.
REQ-012 When En = 0, REQ SHALL be ignored, already pending bits SHALL be retained, and an offer in progress SHALL NOT be withdrawn.
REQ-013 The FSM SHALL have two states, IDLE and OFFER.
REQ-014 In IDLE, VALID SHALL be 0; if En = 1 and PENDING != 0, the FSM SHALL move to OFFER on the next clock, registering CODE from the selection rule.
REQ-015 In OFFER, VALID SHALL be 1 and CODE SHALL be held stable until ACK = 1.
REQ-016 On ACK = 1 in OFFER, the FSM SHALL return to IDLE, giving at most one grant per 2 cycles.
REQ-017 ACK SHALL be ignored while in IDLE.
REQ-018 Latency: a REQ bit sampled at edge t SHALL set PENDING at t, and the block SHALL assert VALID at edge t+1 if IDLE and PENDING was 0.
REQ-019 With RR_MODE = 0, the selected CODE SHALL be the highest set index of PENDING.
REQ-020 With RR_MODE = 1, the selected CODE SHALL be the lowest set index >= ptr; if none exists, it SHALL be the lowest set index overall (wrap).
REQ-021 On each accepted offer (VALID & ACK), the 4-bit ptr SHALL be set to CODE+1 mod 16, so CODE = 15 gives ptr = 0.
REQ-022 ptr SHALL be unused when RR_MODE = 0.

Reset
REQ-023 When reset = 1 at a clock edge, the block SHALL set PENDING = 0, CODE = 0, VALID = 0, state = IDLE and ptr = 0; reset SHALL take priority over all other inputs.
REQ-024 Reset asserted during OFFER SHALL discard the offer and all pending requests, and VALID SHALL be 0 in the cycle after the reset edge.
REQ-025 REQ asserted in the same cycle as reset SHALL NOT be captured.

Structure
REQ-026 The shared package enc16_pkg SHALL hold N_IN = 16, CODE_W = 4, and the state encodings IDLE = 1'b0 and OFFER = 1'b1.
REQ-027 The block SHALL contain one combinational sub-module, pri_enc_16x4 (16-bit vector in; 4-bit index out plus found flag; lowest-index-first).
REQ-028 For round-robin selection, pri_enc_16x4 SHALL be instantiated twice, once on the masked vector (bits >= ptr) and once on the unmasked vector.
REQ-029 For fixed priority, the input to pri_enc_16x4 SHALL be bit-reversed and its result mapped back to the original index.
REQ-030 All registers SHALL be in enc_16x4_arb; the total RTL SHALL be about 150-250 lines.

Verification
REQ-031 The bench SHALL cover: RR_MODE = 0, REQ = 16'h8001 for one cycle, ACK held at 1 -> CODE = 15, then CODE = 0 two cycles later, then VALID = 0 and PENDING = 0.
REQ-032 The bench SHALL cover: RR_MODE = 1, REQ = 16'hFFFF held, ACK = 1 -> CODE sequence 0,1,2,...,15,0, with VALID high every other cycle.
REQ-033 The bench SHALL cover: RR_MODE = 1, ptr = 14 after grant 13, PENDING = 16'h0009 -> CODE = 0 (wrap), then ptr = 1, then CODE = 3.
REQ-034 The bench SHALL cover: offer CODE = 5 with ACK = 0 for 4 cycles, while En toggles and REQ = 16'h0400 -> CODE stays 5 and VALID stays 1; bit 10 is set only in cycles where En = 1.
REQ-035 The bench SHALL cover: during OFFER with CODE = 7, set REQ[7] = 1 and ACK = 1 in the same cycle -> PENDING[7] remains 1 and VALID reasserts with CODE = 7 after the IDLE bubble.
REQ-036 The bench SHALL cover: reset = 1 for one cycle during OFFER with PENDING = 16'h00F0 and REQ = 16'h0001 -> the next cycle shows VALID = 0, CODE = 0, PENDING = 0 and ptr = 0.
